// File: rtl/mux_n_reg_arb.sv
// N-input flow-controlled selector with a registered output stage.
// Ports: clk, reset_n, in_data/in_valid/in_ready, sel, out_data/out_valid/out_ready, out_grant.
module mux_n_reg_arb #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_grant
);

  logic [SELW-1:0]  rr_last;
  logic [SELW-1:0]  cand;
  logic             hit;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;

  assign free = !out_valid | out_ready;

  // Round-robin scans from the channel after the last winner;
  // external select is only a candidate if it names a real channel.
  always_comb begin
    int k;
    k    = 0;
    cand = '0;
    hit  = 1'b0;
    if (MODE == 1) begin
      for (int i = 1; i <= N; i++) begin
        k = (int'(rr_last) + i) % N;
        if (!hit && in_valid[SELW'(k)]) begin
          hit  = 1'b1;
          cand = SELW'(k);
        end
      end
    end else begin
      cand = sel;
      hit  = (int'(sel) < N);
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset_n && hit) begin
      in_ready[cand] = free;
    end
  end

  assign xfer      = hit & in_valid[cand] & in_ready[cand];
  assign cand_data = in_data[int'(cand)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      rr_last   <= SELW'(N-1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cand_data;
      out_grant <= cand;
      if (MODE == 1) begin
        rr_last <= cand;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
